// File: rtl/reg_writeback_queue_if.sv
// Handshake/bus bundle for reg_writeback_queue.
//   Producer side : in_valid, in_ready, in_addr, in_data
//   Register file : wb_stall, write_en, write_reg_addr, write_reg_data
// Modports: master = producer / register-file side, slave = the queue.
interface reg_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wb_stall;
  logic          write_en;
  logic [AW-1:0] write_reg_addr;
  logic [DW-1:0] write_reg_data;

  modport master (
    output in_valid, in_addr, in_data, wb_stall,
    input  in_ready, write_en, write_reg_addr, write_reg_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, wb_stall,
    output in_ready, write_en, write_reg_addr, write_reg_data
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Buffers execute/memory results and drains them in arrival order, one per
// cycle, into the register file's single write port.
// Ports:
//   CLK, reset          clock; synchronous active-high reset
//   bus (slave)         in_valid/in_ready/in_addr/in_data push handshake,
//                       wb_stall input, write_en/write_reg_addr/write_reg_data out
//   lookup_addr1/2      operand addresses from the read stage
//   lookup_hit1/2       a pending write to that register exists
//   lookup_data1/2      newest pending value for that register (0 on miss)
//   count               occupied entries
// Build option: define WBQ_BYPASS_EN to build the lookup scan; otherwise the
// lookup outputs are tied to zero and the queue behaves identically.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         CLK,
  input  logic                         reset,
  reg_writeback_queue_if.slave         bus,
  input  logic [AW-1:0]                lookup_addr1,
  input  logic [AW-1:0]                lookup_addr2,
  output logic                         lookup_hit1,
  output logic                         lookup_hit2,
  output logic [DW-1:0]                lookup_data1,
  output logic [DW-1:0]                lookup_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic push_fire;
  logic push;
  logic pop;

  // in_ready deliberately ignores a same-cycle pop: no pass-through at full.
  assign bus.in_ready = (count < CW'(DEPTH)) && !reset;
  assign push_fire    = bus.in_valid && bus.in_ready;
  // Writes to register 0 complete the handshake but are dropped.
  assign push         = push_fire && (bus.in_addr != '0);
  assign pop          = bus.write_en;

  assign bus.write_en       = (count != '0) && !bus.wb_stall && !reset;
  assign bus.write_reg_addr = bus.write_en ? mem_addr[rd_ptr] : '0;
  assign bus.write_reg_data = bus.write_en ? mem_data[rd_ptr] : '0;

  // Control state: pointers, fill count, entry valid bits
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      // A push only happens below DEPTH, so wr_ptr never equals rd_ptr
      // while a pop is in progress; the two valid-bit updates cannot collide.
      if (push) begin
        entry_vld[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage, not reset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.in_addr;
      mem_data[wr_ptr] <= bus.in_data;
    end
  end

`ifdef WBQ_BYPASS_EN
  // Walk from head (oldest) to tail; later matches overwrite earlier ones so
  // the newest pending value for the register wins.
  function automatic logic [DW:0] scan(input logic [AW-1:0] a);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (entry_vld[idx] && (mem_addr[idx] == a) && (a != '0))
        r = {1'b1, mem_data[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {lookup_hit1, lookup_data1} = '0;
    {lookup_hit2, lookup_data2} = '0;
    if (!reset) begin
      {lookup_hit1, lookup_data1} = scan(lookup_addr1);
      {lookup_hit2, lookup_data2} = scan(lookup_addr2);
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_addr1, lookup_addr2, entry_vld};
  assign lookup_hit1   = 1'b0;
  assign lookup_hit2   = 1'b0;
  assign lookup_data1  = '0;
  assign lookup_data2  = '0;
`endif
endmodule
